// File: rtl/ones_pkg.sv
// Shared constants, width derivations and FSM state type for the ones-count frame accumulator.
package ones_pkg;

  localparam int DEFAULT_MAX_WORDS = 64;
  localparam int COUNT_W = 5;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  function automatic int total_width(input int max_words);
    return $clog2(16 * max_words + 1);
  endfunction

  function automatic int words_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/ones_result_reg.sv
// Output holding register: loads a finished frame, holds it until taken, drops valid on release.
module ones_result_reg #(
  parameter int TOTAL_W = 11,
  parameter int WORDS_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TOTAL_W-1:0] load_total,
  input  logic [WORDS_W-1:0] load_words,
  input  logic               load_ovf,
  input  logic               load_bad,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [TOTAL_W-1:0] out_total,
  output logic [WORDS_W-1:0] out_words,
  output logic               out_ovf,
  output logic               out_bad
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_total <= '0;
      out_words <= '0;
      out_ovf   <= 1'b0;
      out_bad   <= 1'b0;
    end else if (load) begin
      // A new result replaces a held one in the same cycle it is taken.
      out_valid <= 1'b1;
      out_total <= load_total;
      out_words <= load_words;
      out_ovf   <= load_ovf;
      out_bad   <= load_bad;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Sums per-word ones counts over a frame, with clamping, word-count saturation and sticky flags.
module ones_frame_accumulator
  import ones_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  localparam int TOTAL_W = total_width(MAX_WORDS),
  localparam int WORDS_W = words_width(MAX_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] in_count,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_total,
  output logic [WORDS_W-1:0] out_words,
  output logic               out_ovf,
  output logic               out_bad
);

  state_t             state, state_next;
  logic [TOTAL_W-1:0] acc, acc_next;
  logic [WORDS_W-1:0] words, words_next;
  logic               ovf, ovf_next;
  logic               bad, bad_next;
  logic               accept;
  logic               saturated;
  logic               over;
  logic [COUNT_W-1:0] clamped;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign over      = in_count > COUNT_MAX;
  assign clamped   = over ? COUNT_MAX : in_count;
  assign saturated = (words == WORDS_W'(MAX_WORDS));

  // Frame totals including the current beat; a beat at saturation is dropped but flagged.
  always_comb begin
    acc_next   = saturated ? acc : acc + TOTAL_W'(clamped);
    words_next = saturated ? words : words + WORDS_W'(1);
    ovf_next   = ovf || saturated;
    bad_next   = bad || over;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = in_last ? HOLD : ACCUM;
    end else if (state == HOLD && out_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      words <= '0;
      ovf   <= 1'b0;
      bad   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (in_last) begin
          acc   <= '0;
          words <= '0;
          ovf   <= 1'b0;
          bad   <= 1'b0;
        end else begin
          acc   <= acc_next;
          words <= words_next;
          ovf   <= ovf_next;
          bad   <= bad_next;
        end
      end
    end
  end

  ones_result_reg #(
    .TOTAL_W (TOTAL_W),
    .WORDS_W (WORDS_W)
  ) u_result (
    .clk        (clk),
    .rst        (rst),
    .load       (accept && in_last),
    .load_total (acc_next),
    .load_words (words_next),
    .load_ovf   (ovf_next),
    .load_bad   (bad_next),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_total  (out_total),
    .out_words  (out_words),
    .out_ovf    (out_ovf),
    .out_bad    (out_bad)
  );

endmodule
